sram_bist: RTL

Built-in self-test controller that sits directly upstream of the `sram_16x8` synchronous SRAM and drives its `addr`/`din`/`we` pins. On `start` it runs a March C- style sequence: write the background pattern, read and invert it ascending, read and restore it descending, then do a final read. Each read is compared against the expected word, and the block reports pass/fail with the first failing address and data. It is the test front-end for the SRAM macro, and its mux/arbiter sits in front of the macro next to the functional write path.

---
 rtl/sram_bist_pkg.sv | 18 +
 rtl/sram_bist_if.sv | 13 +
 rtl/sram_bist_addr_gen.sv | 35 +++
 rtl/sram_bist.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types and constants for the SRAM BIST controller
package sram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        M0_W,
        M1_R,
        M1_W,
        M2_R,
        M2_W,
        M3_R,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] bg_pattern_default = 8'h55;

endpackage

// File: rtl/sram_bist_if.sv
// rtl/sram_bist_if.sv - SRAM pin bundle between BIST controller and memory macro
interface sram_bist_if #(
    parameter int addr_width = 4,
    parameter int word_width = 8
);
    logic [addr_width-1:0] sram_addr;
    logic [word_width-1:0] sram_din;
    logic                  sram_we;
    logic [word_width-1:0] sram_dout;

    modport master (output sram_addr, output sram_din, output sram_we, input sram_dout);
    modport slave  (input sram_addr, input sram_din, input sram_we, output sram_dout);
endinterface

// File: rtl/sram_bist_addr_gen.sv
// rtl/sram_bist_addr_gen.sv - up/down address counter with load-0/load-max and end flags
module sram_bist_addr_gen #(
    parameter int                    addr_width = 4,
    parameter logic [addr_width-1:0] max_addr   = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load0,
    input  logic                  loadmax,
    input  logic                  inc,
    input  logic                  dec,
    output logic [addr_width-1:0] addr,
    output logic                  at_max,
    output logic                  at_min
);

    // Address register; loads win over stepping so march boundaries never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load0) begin
            addr <= '0;
        end else if (loadmax) begin
            addr <= max_addr;
        end else if (inc) begin
            addr <= addr + 1'b1;
        end else if (dec) begin
            addr <= addr - 1'b1;
        end
    end

    assign at_max = (addr == max_addr);
    assign at_min = (addr == '0);

endmodule

// File: rtl/sram_bist.sv
// rtl/sram_bist.sv - March C- style BIST controller for a synchronous SRAM
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int                    addr_width = 4,
    parameter int                    word_depth = 16,
    parameter int                    word_width = 8,
    parameter logic [word_width-1:0] bg_pattern = bg_pattern_default
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [addr_width-1:0] fail_addr,
    output logic [word_width-1:0] fail_data,
    sram_bist_if.master           sram
);

    localparam logic [addr_width-1:0] addr_max = addr_width'(word_depth - 1);

    state_t                state;
    logic [addr_width-1:0] addr;
    logic                  at_max;
    logic                  at_min;
    logic                  ctr_load0;
    logic                  ctr_loadmax;
    logic                  ctr_inc;
    logic                  ctr_dec;
    logic [word_width-1:0] din_q;
    logic                  we_q;
    logic                  cmp_en;
    logic [addr_width-1:0] cmp_addr;
    logic                  cmp_now;
    logic [word_width-1:0] cmp_exp;
    logic [addr_width-1:0] cmp_a;
    logic                  mismatch;

    sram_bist_addr_gen #(
        .addr_width(addr_width),
        .max_addr  (addr_max)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load0  (ctr_load0),
        .loadmax(ctr_loadmax),
        .inc    (ctr_inc),
        .dec    (ctr_dec),
        .addr   (addr),
        .at_max (at_max),
        .at_min (at_min)
    );

    assign sram.sram_addr = addr;
    assign sram.sram_din  = din_q;
    assign sram.sram_we   = we_q;

    // Which word is being checked this edge: M1/M2 check the current address, M3 checks one read behind
    always_comb begin
        cmp_now = 1'b0;
        cmp_exp = bg_pattern;
        cmp_a   = addr;
        case (state)
            M1_W: cmp_now = 1'b1;
            M2_W: begin
                cmp_now = 1'b1;
                cmp_exp = ~bg_pattern;
            end
            M3_R, DRAIN: begin
                cmp_now = cmp_en;
                cmp_a   = cmp_addr;
            end
            default: ;
        endcase
        mismatch = cmp_now && (sram.sram_dout != cmp_exp);
    end

    // Address counter steering for each march element
    always_comb begin
        ctr_load0   = 1'b0;
        ctr_loadmax = 1'b0;
        ctr_inc     = 1'b0;
        ctr_dec     = 1'b0;
        case (state)
            IDLE, DONE: ctr_load0 = start;
            M0_W: begin
                ctr_load0 = at_max;
                ctr_inc   = !at_max;
            end
            M1_W: begin
                ctr_loadmax = !mismatch && at_max;
                ctr_inc     = !mismatch && !at_max;
            end
            M2_W: begin
                ctr_load0 = !mismatch && at_min;
                ctr_dec   = !mismatch && !at_min;
            end
            M3_R: ctr_inc = !mismatch && !at_max;
            default: ;
        endcase
    end

    // Sequencer with registered SRAM controls, status and first-failure latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            din_q     <= '0;
            we_q      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            cmp_en    <= 1'b0;
            cmp_addr  <= '0;
        end else begin
            cmp_en <= 1'b0;
            if (mismatch) begin
                // First failure ends the run; controls fall back to read so nothing else is written
                state     <= DONE;
                we_q      <= 1'b1;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
                fail_addr <= cmp_a;
                fail_data <= sram.sram_dout;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state     <= M0_W;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            pass      <= 1'b0;
                            fail_addr <= '0;
                            fail_data <= '0;
                            we_q      <= 1'b0;
                            din_q     <= bg_pattern;
                        end
                    end
                    M0_W: begin
                        if (at_max) begin
                            state <= M1_R;
                            we_q  <= 1'b1;
                        end
                    end
                    M1_R: begin
                        state <= M1_W;
                        we_q  <= 1'b0;
                        din_q <= ~bg_pattern;
                    end
                    M1_W: begin
                        state <= at_max ? M2_R : M1_R;
                        we_q  <= 1'b1;
                    end
                    M2_R: begin
                        state <= M2_W;
                        we_q  <= 1'b0;
                        din_q <= bg_pattern;
                    end
                    M2_W: begin
                        state <= at_min ? M3_R : M2_R;
                        we_q  <= 1'b1;
                    end
                    M3_R: begin
                        cmp_en   <= 1'b1;
                        cmp_addr <= addr;
                        if (at_max) state <= DRAIN;
                    end
                    DRAIN: begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
